// File: rtl/dec_pkg.sv
// Shared constants for the decrement unit: default operand width and underflow modes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Imported by dec_unit and by anything that instantiates it, so the
// DATAWIDTH default and SATURATE encodings are defined in one place.
package dec_pkg;

    // Default operand/result width in bits.
    localparam int DEC_DATAWIDTH = 8;

    // Underflow handling modes for the SATURATE parameter.
    localparam int WRAP  = 0;  // a=0 decrements to all-ones
    localparam int CLAMP = 1;  // a=0 decrements to zero

endpackage : dec_pkg

// File: rtl/dec_unit.sv
// Registered decrement: d = a - 1, with underflow flag, wrap or clamp-at-zero.
// Latency: 1 cycle from the sampling edge; throughput one operand per cycle.
// Backpressure: none; every a_valid=1 cycle is accepted.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset; clears d, d_valid, underflow
//   a          unsigned operand, sampled only when a_valid=1
//   a_valid    operand qualifier
//   d          registered result; holds its value on cycles without an operand
//   d_valid    one-cycle pulse per accepted operand
//   underflow  registered flag, high with d_valid when the accepted a was 0
//
// DATAWIDTH legal range is 2..64. All outputs come straight from flops.
module dec_unit
    import dec_pkg::*;
#(
    parameter int DATAWIDTH = DEC_DATAWIDTH,
    parameter int SATURATE  = WRAP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] a,
    input  logic                 a_valid,
    output logic [DATAWIDTH-1:0] d,
    output logic                 d_valid,
    output logic                 underflow
);

    localparam logic [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);

    logic                 a_is_zero;
    logic [DATAWIDTH-1:0] d_next;

    // Combinational decrement / underflow path.
    always_comb begin
        a_is_zero = (a == '0);
        d_next    = a - ONE;
        if ((SATURATE == CLAMP) && a_is_zero) begin
            d_next = '0;
        end
    end

    // Output register stage. d only loads on an accepted operand; the
    // qualifier gates the flag so a garbage a with a_valid=0 cannot leak
    // into underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d         <= '0;
            d_valid   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            d_valid   <= a_valid;
            underflow <= a_valid ? a_is_zero : 1'b0;
            if (a_valid) begin
                d <= d_next;
            end
        end
    end

endmodule : dec_unit

// File: tb/tb_dec_unit.sv
// Self-checking bench for dec_unit: one wrap-mode and one clamp-mode instance
// driven with identical stimulus, checked against a scoreboard queue.
module tb_dec_unit;
    import dec_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic         a_valid;

    logic [W-1:0] d_w, d_c;
    logic         v_w, v_c, uf_w, uf_c;

    always #5 clk = ~clk;

    dec_unit #(.DATAWIDTH(W), .SATURATE(WRAP)) u_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .a_valid   (a_valid),
        .d         (d_w),
        .d_valid   (v_w),
        .underflow (uf_w)
    );

    dec_unit #(.DATAWIDTH(W), .SATURATE(CLAMP)) u_clamp (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .a_valid   (a_valid),
        .d         (d_c),
        .d_valid   (v_c),
        .underflow (uf_c)
    );

    typedef struct {
        logic [W-1:0] a;
        logic         vld;
        logic [W-1:0] exp_dw;
        logic [W-1:0] exp_dc;
        logic         exp_v;
        logic         exp_uf;
    } vec_t;

    typedef struct {
        logic [W-1:0] dw;
        logic [W-1:0] dc;
        logic         v;
        logic         uf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, " d_wrap"},     d_w,  e.dw);
        chk({tag, " d_clamp"},    d_c,  e.dc);
        chk({tag, " vld_wrap"},   W'(v_w),  W'(e.v));
        chk({tag, " vld_clamp"},  W'(v_c),  W'(e.v));
        chk({tag, " uf_wrap"},    W'(uf_w), W'(e.uf));
        chk({tag, " uf_clamp"},   W'(uf_c), W'(e.uf));
    endtask

    // Compare the oldest pending expectation against what the DUTs show now.
    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, nothing expected", tag);
        end else begin
            e = sb.pop_front();
            chk_all(tag, e);
        end
    endtask

    // One cycle: check the previous result, then drive a new operand and
    // record what it should produce one edge later.
    task automatic run_vec(input string tag, input vec_t v);
        exp_t e;
        @(negedge clk);
        if (sb.size() != 0) check_pop(tag);
        a       = v.a;
        a_valid = v.vld;
        e.dw = v.exp_dw;
        e.dc = v.exp_dc;
        e.v  = v.exp_v;
        e.uf = v.exp_uf;
        sb.push_back(e);
    endtask

    function automatic vec_t mk(input logic [W-1:0] av, input logic vl,
                                input logic [W-1:0] dw, input logic [W-1:0] dc,
                                input logic ev, input logic euf);
        vec_t v;
        v.a = av; v.vld = vl; v.exp_dw = dw; v.exp_dc = dc; v.exp_v = ev; v.exp_uf = euf;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t zero_e;
        zero_e.dw = '0; zero_e.dc = '0; zero_e.v = 1'b0; zero_e.uf = 1'b0;

        //           a    vld  d_wrap d_clamp vld uf
        vecs[0]  = mk(8'd10,  1, 8'd9,   8'd9,   1, 0);  // single operand
        vecs[1]  = mk(8'd77,  0, 8'd9,   8'd9,   0, 0);  // idle: hold
        vecs[2]  = mk(8'd10,  1, 8'd9,   8'd9,   1, 0);  // back-to-back pair
        vecs[3]  = mk(8'd20,  1, 8'd19,  8'd19,  1, 0);
        vecs[4]  = mk(8'd0,   1, 8'd255, 8'd0,   1, 1);  // underflow
        vecs[5]  = mk(8'd255, 1, 8'd254, 8'd254, 1, 0);  // max operand
        vecs[6]  = mk(8'd1,   1, 8'd0,   8'd0,   1, 0);  // a=1 -> 0, no underflow
        vecs[7]  = mk(8'd0,   1, 8'd255, 8'd0,   1, 1);
        vecs[8]  = mk(8'd0,   0, 8'd255, 8'd0,   0, 0);  // idle after underflow
        vecs[9]  = mk(8'd128, 1, 8'd127, 8'd127, 1, 0);
        vecs[10] = mk(8'd2,   1, 8'd1,   8'd1,   1, 0);
        vecs[11] = mk(8'd3,   0, 8'd1,   8'd1,   0, 0);

        // Reset state, observed before any clock edge.
        rst_n   = 1'b0;
        a       = '0;
        a_valid = 1'b0;
        #1;
        chk_all("reset", zero_e);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven main sequence.
        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Idle with a toggling randomly (and once undriven): outputs hold d=1.
        for (int i = 0; i < 5; i++)
            run_vec($sformatf("idle%0d", i),
                    mk(W'($urandom_range(0, 255)), 1'b0, 8'd1, 8'd1, 1'b0, 1'b0));
        run_vec("idle_x", mk('x, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0));

        // Mid-stream asynchronous reset with an operand pending.
        run_vec("pre_rst", mk(8'd50, 1'b1, 8'd49, 8'd49, 1'b1, 1'b0));
        @(negedge clk);
        check_pop("pre_rst");
        a       = 8'd0;
        a_valid = 1'b1;           // pending operand, would set underflow
        #2;
        rst_n = 1'b0;             // between edges
        #1;
        chk_all("rst_async", zero_e);
        @(negedge clk);           // the edge in reset must not accept a
        chk_all("rst_held", zero_e);
        a_valid = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk_all("rst_release", zero_e);

        // First operand after release is processed normally.
        run_vec("post_rst", mk(8'd5, 1'b1, 8'd4, 8'd4, 1'b1, 1'b0));
        run_vec("post_idle", mk(8'd9, 1'b0, 8'd4, 8'd4, 1'b0, 1'b0));
        @(negedge clk);
        check_pop("post_idle");

        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, 0 expected", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dec_unit
